// File: rtl/fat32_pkg.sv
// Shared types and constants for the FAT32 read path.
package fat32_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int FILE_SIZE_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DRAIN
    } state_t;

endpackage

// File: rtl/fat32_read_unloader_if.sv
// Byte stream (valid/ready) carrying file data and an end-of-file marker.
interface fat32_read_unloader_if;
    import fat32_pkg::*;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push is accepted when full only if a pop coincides.
module byte_fifo
    import fat32_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 9,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rd_ptr_q[ADDR_W-1:0]];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/fat32_read_unloader.sv
// Turns controller read strobes into a trimmed byte stream with completion/error status.
module fat32_read_unloader
    import fat32_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [FILE_SIZE_W-1:0]    file_size,
    input  logic                      ctrl_busy,
    input  logic [7:0]                incoming_byte,
    input  logic                      finished_byte,
    fat32_read_unloader_if.master     m_if,
    output logic                      active,
    output logic                      done,
    output logic                      truncated,
    output logic                      overflow,
    output logic [FILE_SIZE_W-1:0]    byte_count
);

    state_t                 state_q, state_d;
    logic [FILE_SIZE_W-1:0] size_q, size_d;
    logic [FILE_SIZE_W-1:0] count_q, count_d;
    logic                   trunc_q, trunc_d;
    logic                   ovf_q, ovf_d;

    logic       fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [8:0] fifo_wdata, fifo_rdata;
    logic       capture, drain_done, launch;

    always_comb begin
        launch     = (state_q == IDLE) && start;
        capture    = (state_q == CAPTURE) && finished_byte && (count_q < size_q);
        fifo_pop   = !fifo_empty && m_if.m_ready;
        fifo_push  = capture && (!fifo_full || fifo_pop);
        fifo_wdata = {(count_q == size_q - 1'b1), incoming_byte};
        fifo_flush = launch;
        drain_done = (state_q == DRAIN) && fifo_empty && !ctrl_busy;
    end

    byte_fifo #(.DEPTH(DEPTH), .WIDTH(9), .ADDR_W(ADDR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (file_size == '0) ? DRAIN : ARM;
            ARM:     if (ctrl_busy) state_d = CAPTURE;
            CAPTURE: if (count_q == size_q || !ctrl_busy) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !ctrl_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bytes that miss a full FIFO are still counted so byte_count tracks the file, not the stream.
    always_comb begin
        size_d  = size_q;
        count_d = count_q;
        trunc_d = trunc_q;
        ovf_d   = ovf_q;
        if (launch) begin
            size_d  = file_size;
            count_d = '0;
            trunc_d = 1'b0;
            ovf_d   = 1'b0;
        end
        if (capture) begin
            if (count_q != '1) count_d = count_q + 1'b1;
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
        if ((state_q == CAPTURE) && !ctrl_busy && (count_q < size_q)) trunc_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            size_q  <= size_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        m_if.m_valid = !fifo_empty;
        m_if.m_data  = fifo_empty ? 8'h00 : fifo_rdata[7:0];
        m_if.m_last  = !fifo_empty && fifo_rdata[8];
        done         = drain_done;
        active       = (state_q != IDLE) && !drain_done;
        truncated    = trunc_q;
        overflow     = ovf_q;
        byte_count   = count_q;
    end

endmodule
